axi4l_slv_regs: RTL and testbench

- AXI4-Lite slave (responder) exposing NUM_REGS 32-bit read/write control registers at BASE_ADDR.
- It is the RTL counterpart of the AXI4-Lite master in the axi4l_mst block design.
- It replaces the slave VIP memory model, so master-side tests can target real register RTL.
- Register contents are exported as a flat bus for downstream logic.

---
 rtl/axi4l_slv_pkg.sv | 39 +++
 rtl/axi4l_slv_decode.sv | 29 ++
 rtl/axi4l_slv_regs.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4l_slv_regs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_slv_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi4l_slv_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    // Byte-lane merge: lanes with strobe set take the new data, others keep the old.
    function automatic logic [DATA_W-1:0] apply_strb(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4l_slv_decode.sv
// Address window decode: maps a byte address onto a register index and range flag.
// With AXI4L_SLV_STRICT_ALIGN_EN defined, addresses that are not word aligned
// are reported as out of range.
module axi4l_slv_decode #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h44A0_0000,
    parameter int                NUM_REGS  = 8,
    parameter int                IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              in_range
);

    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(NUM_REGS * 4);

    logic [ADDR_W-1:0] off;

    // Offset from the window base; the compare uses the full offset so wrap-around is caught.
    always_comb begin
        off      = addr - BASE_ADDR;
        idx      = off[IDX_W+1:2];
        in_range = (addr >= BASE_ADDR) && (off < SPAN);
`ifdef AXI4L_SLV_STRICT_ALIGN_EN
        in_range = in_range && (addr[1:0] == 2'b00);
`endif
    end

endmodule

// File: rtl/axi4l_slv_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers at BASE_ADDR.
// Write and read paths are independent; one outstanding transaction per channel.
// Optional macro AXI4L_SLV_STRICT_ALIGN_EN rejects unaligned addresses with SLVERR.
module axi4l_slv_regs
    import axi4l_slv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h44A0_0000,
    parameter int                NUM_REGS  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic [2:0]                 s_axi_awprot,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [DATA_W-1:0]          s_axi_wdata,
    input  logic [STRB_W-1:0]          s_axi_wstrb,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [ADDR_W-1:0]          s_axi_araddr,
    input  logic [2:0]                 s_axi_arprot,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [DATA_W-1:0]          s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Protection attributes carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    logic [DATA_W-1:0] regs [NUM_REGS];

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;
    logic      awready, awready_nxt, wready, wready_nxt, arready, arready_nxt;
    logic      aw_full, aw_full_nxt, w_full, w_full_nxt;
    logic      bvalid, bvalid_nxt, rvalid, rvalid_nxt;
    resp_t     bresp_q, bresp_nxt, rresp_q, rresp_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;

    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs, w_hs, ar_hs, aw_have, w_have, wr_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;

    assign aw_hs   = s_axi_awvalid & awready;
    assign w_hs    = s_axi_wvalid & wready;
    assign ar_hs   = s_axi_arvalid & arready;
    assign aw_have = aw_hs | aw_full;
    assign w_have  = w_hs | w_full;

    // A channel completing this cycle supplies its payload directly; otherwise use the latched copy.
    assign wr_addr = aw_full ? aw_addr_q : s_axi_awaddr;
    assign wr_data = w_full  ? w_data_q  : s_axi_wdata;
    assign wr_strb = w_full  ? w_strb_q  : s_axi_wstrb;

    axi4l_slv_decode #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) u_aw_decode (
        .addr(wr_addr), .idx(wr_idx), .in_range(wr_in_range)
    );

    axi4l_slv_decode #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
    ) u_ar_decode (
        .addr(s_axi_araddr), .idx(rd_idx), .in_range(rd_in_range)
    );

    // Write FSM next state: collect AW and W in any order, commit once both are present.
    always_comb begin
        wr_state_nxt = wr_state;
        awready_nxt  = awready;
        wready_nxt   = wready;
        aw_full_nxt  = aw_full;
        w_full_nxt   = w_full;
        bvalid_nxt   = bvalid;
        bresp_nxt    = bresp_q;
        wr_commit    = 1'b0;
        case (wr_state)
            W_IDLE, W_WAIT: begin
                if (aw_have && w_have) begin
                    wr_commit    = wr_in_range;
                    bresp_nxt    = wr_in_range ? OKAY : SLVERR;
                    bvalid_nxt   = 1'b1;
                    aw_full_nxt  = 1'b0;
                    w_full_nxt   = 1'b0;
                    awready_nxt  = 1'b0;
                    wready_nxt   = 1'b0;
                    wr_state_nxt = W_RESP;
                end else begin
                    aw_full_nxt  = aw_have;
                    w_full_nxt   = w_have;
                    awready_nxt  = !aw_have;
                    wready_nxt   = !w_have;
                    wr_state_nxt = (aw_have || w_have) ? W_WAIT : W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_nxt   = 1'b0;
                    awready_nxt  = 1'b1;
                    wready_nxt   = 1'b1;
                    wr_state_nxt = W_IDLE;
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state: capture data on the AR handshake, hold it until rready.
    always_comb begin
        rd_state_nxt = rd_state;
        arready_nxt  = arready;
        rvalid_nxt   = rvalid;
        rresp_nxt    = rresp_q;
        rdata_nxt    = rdata_q;
        case (rd_state)
            R_IDLE: begin
                arready_nxt = 1'b1;
                if (ar_hs) begin
                    rvalid_nxt   = 1'b1;
                    arready_nxt  = 1'b0;
                    rdata_nxt    = rd_in_range ? regs[rd_idx] : '0;
                    rresp_nxt    = rd_in_range ? OKAY : SLVERR;
                    rd_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_nxt   = 1'b0;
                    arready_nxt  = 1'b1;
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Control and response registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            arready  <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid   <= 1'b0;
            rvalid   <= 1'b0;
            bresp_q  <= OKAY;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            awready  <= awready_nxt;
            wready   <= wready_nxt;
            arready  <= arready_nxt;
            aw_full  <= aw_full_nxt;
            w_full   <= w_full_nxt;
            bvalid   <= bvalid_nxt;
            rvalid   <= rvalid_nxt;
            bresp_q  <= bresp_nxt;
            rresp_q  <= rresp_nxt;
            rdata_q  <= rdata_nxt;
        end
    end

    // Payload latches for a channel that handshakes before its partner; qualified by the full flags.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= s_axi_awaddr;
        if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    // Register file update and per-register write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (wr_commit) begin
                regs[wr_idx]         <= apply_strb(regs[wr_idx], wr_data, wr_strb);
                reg_wr_pulse[wr_idx] <= 1'b1;
            end
        end
    end

    // Flatten the register file for downstream logic.
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_out[DATA_W*i +: DATA_W] = regs[i];
    end

    assign s_axi_awready = awready;
    assign s_axi_wready  = wready;
    assign s_axi_arready = arready;
    assign s_axi_bvalid  = bvalid;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi4l_slv_regs.sv
// Directed and randomized bench for axi4l_slv_regs with a word-array reference model.
module tb_axi4l_slv_regs;

    localparam logic [31:0] BASE  = 32'h44A0_0000;
    localparam int          NREGS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       awaddr = '0, araddr = '0, wdata = '0;
    logic [2:0]        awprot = '0, arprot = '0;
    logic [3:0]        wstrb = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [NREGS*32-1:0] reg_out;
    logic [NREGS-1:0]  reg_wr_pulse;

    always #5 clk = ~clk;

    axi4l_slv_regs #(.ADDR_W(32), .BASE_ADDR(BASE), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [31:0] mdl [NREGS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the register window as a plain word array.
    function automatic bit m_in_range(input logic [31:0] a);
        bit ok;
        ok = (a >= BASE) && ((a - BASE) < 32'(NREGS * 4));
`ifdef AXI4L_SLV_STRICT_ALIGN_EN
        ok = ok && (a % 4 == 0);
`endif
        return ok;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (m_in_range(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[m_idx(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            chk($sformatf("%s_reg%0d", tag, i), reg_out[32*i +: 32], mdl[i]);
    endtask

    // Full write transaction; W leads AW by aw_dly cycles, bready held low b_dly cycles.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int b_dly,
                             output logic [1:0] resp, output logic [NREGS-1:0] p_at,
                             output logic [NREGS-1:0] p_after);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (aw_dly == 0);
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
            if (w_done && !aw_done) begin
                chk("w_early_no_bvalid", {31'b0, bvalid}, 32'd0);
                chk("w_early_no_pulse", {24'b0, reg_wr_pulse}, 32'd0);
            end
            if (!aw_done && !awvalid && n >= aw_dly) awvalid = 1'b1;
        end
        if (n >= 50) chk("wr_handshake_timeout", 32'd0, 32'd1);
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("wr_b_latency", n, 32'd0);
        resp = bresp;
        p_at = reg_wr_pulse;
        for (int k = 0; k < b_dly; k++) begin
            tick();
            chk("b_stall_valid", {31'b0, bvalid}, 32'd1);
            chk("b_stall_resp", {30'b0, bresp}, {30'b0, resp});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        p_after = reg_wr_pulse;
        chk("b_dropped", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        if (n >= 20) chk("rd_arready_timeout", 32'd0, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rd_latency", {31'b0, rvalid}, 32'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_dropped", {31'b0, rvalid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]       resp;
        logic [31:0]      d, a, exp_d;
        logic [3:0]       s;
        logic [NREGS-1:0] p_at, p_after;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_bresp", {30'b0, bresp}, 32'd0);
        chk("rst_rresp", {30'b0, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pulse", {24'b0, reg_wr_pulse}, 32'd0);
        check_regs("rst");
        rst = 1'b0;
        tick();
        chk("rel_awready", {31'b0, awready}, 32'd1);
        chk("rel_wready", {31'b0, wready}, 32'd1);
        chk("rel_arready", {31'b0, arready}, 32'd1);

        // Basic write and readback of reg0
        axi_write(BASE, 32'hDEADBEEF, 4'hF, 0, 0, resp, p_at, p_after);
        m_write(BASE, 32'hDEADBEEF, 4'hF);
        chk("t1_bresp", {30'b0, resp}, 32'd0);
        chk("t1_pulse", {24'b0, p_at}, 32'h1);
        chk("t1_pulse_after", {24'b0, p_after}, 32'h0);
        chk("t1_reg0", reg_out[31:0], 32'hDEADBEEF);
        axi_read(BASE, d, resp);
        chk("t1_rdata", d, 32'hDEADBEEF);
        chk("t1_rresp", {30'b0, resp}, 32'd0);

        // Byte-strobe merge into reg2
        axi_write(BASE + 8, 32'h11223344, 4'hF, 0, 0, resp, p_at, p_after);
        m_write(BASE + 8, 32'h11223344, 4'hF);
        axi_write(BASE + 8, 32'hAABBCCDD, 4'b0101, 0, 0, resp, p_at, p_after);
        m_write(BASE + 8, 32'hAABBCCDD, 4'b0101);
        chk("t2_merge", reg_out[95:64], 32'h11BB33DD);
        chk("t2_pulse", {24'b0, p_at}, 32'h4);

        // Out-of-range write and read
        axi_write(BASE + 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, resp, p_at, p_after);
        chk("t3_bresp", {30'b0, resp}, 32'd2);
        chk("t3_no_pulse", {24'b0, p_at}, 32'd0);
        check_regs("t3");
        axi_read(BASE + 32'h100, d, resp);
        chk("t3_rdata", d, 32'd0);
        chk("t3_rresp", {30'b0, resp}, 32'd2);

        // W three cycles ahead of AW, bready stalled five cycles
        axi_write(BASE + 12, 32'h0BADF00D, 4'hF, 3, 5, resp, p_at, p_after);
        m_write(BASE + 12, 32'h0BADF00D, 4'hF);
        chk("t4_bresp", {30'b0, resp}, 32'd0);
        chk("t4_pulse", {24'b0, p_at}, 32'h8);
        chk("t4_reg3", reg_out[127:96], 32'h0BADF00D);

        // Write and read of reg1 on the same edge returns the old value
        axi_write(BASE + 4, 32'h5, 4'hF, 0, 0, resp, p_at, p_after);
        m_write(BASE + 4, 32'h5, 4'hF);
        awaddr = BASE + 4; wdata = 32'h7; wstrb = 4'hF; araddr = BASE + 4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t5_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t5_bvalid", {31'b0, bvalid}, 32'd1);
        chk("t5_old_rdata", rdata, 32'h5);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        m_write(BASE + 4, 32'h7, 4'hF);
        axi_read(BASE + 4, d, resp);
        chk("t5_new_rdata", d, 32'h7);

        // Unaligned accesses: SLVERR in strict build, aligned word otherwise
        axi_read(BASE + 2, d, resp);
        exp_d = m_in_range(BASE + 2) ? mdl[0] : 32'd0;
        chk("t6_unaligned_rdata", d, exp_d);
        chk("t6_unaligned_rresp", {30'b0, resp}, m_in_range(BASE + 2) ? 32'd0 : 32'd2);
        axi_write(BASE + 6, 32'h1234_5678, 4'hF, 0, 0, resp, p_at, p_after);
        chk("t6_unaligned_bresp", {30'b0, resp}, m_in_range(BASE + 6) ? 32'd0 : 32'd2);
        m_write(BASE + 6, 32'h1234_5678, 4'hF);
        check_regs("t6");

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int pick;
            pick = $urandom_range(0, 11);
            if (pick < 10)       a = BASE + 32'(pick * 4) + 32'($urandom_range(0, 3));
            else if (pick == 10) a = BASE - 4;
            else                 a = BASE + 32'h1000;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), resp, p_at, p_after);
                chk("rnd_bresp", {30'b0, resp}, m_in_range(a) ? 32'd0 : 32'd2);
                chk("rnd_pulse", {24'b0, p_at}, m_in_range(a) ? (32'd1 << m_idx(a)) : 32'd0);
                chk("rnd_pulse_after", {24'b0, p_after}, 32'd0);
                m_write(a, d, s);
            end else begin
                axi_read(a, d, resp);
                chk("rnd_rdata", d, m_in_range(a) ? mdl[m_idx(a)] : 32'd0);
                chk("rnd_rresp", {30'b0, resp}, m_in_range(a) ? 32'd0 : 32'd2);
            end
            if (it % 10 == 9) check_regs("rnd");
        end

        // Reset while a write response is pending
        awaddr = BASE + 4; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t7_bvalid_pending", {31'b0, bvalid}, 32'd1);
        rst = 1'b1;
        tick();
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        chk("t7_bvalid_cleared", {31'b0, bvalid}, 32'd0);
        chk("t7_awready_in_rst", {31'b0, awready}, 32'd0);
        chk("t7_pulse_in_rst", {24'b0, reg_wr_pulse}, 32'd0);
        check_regs("t7");
        rst = 1'b0;
        tick();
        chk("t7_awready_rel", {31'b0, awready}, 32'd1);
        chk("t7_wready_rel", {31'b0, wready}, 32'd1);
        chk("t7_arready_rel", {31'b0, arready}, 32'd1);
        axi_read(BASE + 4, d, resp);
        chk("t7_reg1_cleared", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
